// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select through channels 0..3,
// samples the mux output after a settle time and publishes a 4-bit word.
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_y,
    output logic [1:0] sel,
    output logic [3:0] word,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for start, sel parked on channel 0
    // SCAN  | stepping channels, settling then sampling each one
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    state_t     state;
    logic [1:0] ch;
    logic [3:0] cnt;
    logic [2:0] shadow;
    logic [3:0] next_word;

    assign next_word = {mux_y, shadow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= 2'd0;
            cnt     <= 4'd0;
            shadow  <= 3'd0;
            sel     <= 2'd0;
            word    <= 4'd0;
            valid   <= 1'b0;
            changed <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    sel <= 2'd0;
                    if (start) begin
                        state <= SCAN;
                        ch    <= 2'd0;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // cnt never passes SETTLE, so inequality doubles as "still settling"
                    if (cnt != SETTLE_C) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt <= 4'd0;
                        ch  <= ch + 2'd1;
                        sel <= ch + 2'd1;
                        case (ch)
                            2'd0: shadow[0] <= mux_y;
                            2'd1: shadow[1] <= mux_y;
                            2'd2: shadow[2] <= mux_y;
                            default: begin
                                word    <= next_word;
                                valid   <= 1'b1;
                                changed <= (next_word != word);
                                if (!cont) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=1, one with SETTLE=0,
// each fed by a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start1, start0, cont1, cont0;
    logic [3:0] mi1, mi0;
    logic       y1, y0;
    logic [1:0] sel1, sel0;
    logic [3:0] word1, word0;
    logic       valid1, valid0, changed1, changed0, busy1, busy0;

    int n_cmp = 0;
    int n_bad = 0;

    assign y1 = mi1[sel1];
    assign y0 = mi0[sel0];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .mux_y(y1),
        .sel(sel1), .word(word1), .valid(valid1), .changed(changed1), .busy(busy1)
    );

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .mux_y(y0),
        .sel(sel0), .word(word0), .valid(valid0), .changed(changed0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         s;
        logic [3:0] iv;
        logic       poke;
        logic [3:0] ew;
        logic       ec;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input bit s, input string tag);
        chk({tag, "_sel"},     s ? sel1 : sel0, 0);
        chk({tag, "_word"},    s ? word1 : word0, 0);
        chk({tag, "_valid"},   s ? valid1 : valid0, 0);
        chk({tag, "_changed"}, s ? changed1 : changed0, 0);
        chk({tag, "_busy"},    s ? busy1 : busy0, 0);
    endtask

    task automatic run_scan(input bit s, input logic [3:0] iv, input logic pk,
                            input logic [3:0] ew, input logic ec);
        int n   = s ? 8 : 4;
        int per = s ? 2 : 1;
        @(negedge clk);
        if (s) begin mi1 = iv; start1 = 1'b1; end
        else   begin mi0 = iv; start0 = 1'b1; end
        @(posedge clk); #1;
        chk("e0_busy",  s ? busy1 : busy0, 1);
        chk("e0_sel",   s ? sel1 : sel0, 0);
        chk("e0_valid", s ? valid1 : valid0, 0);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            if (s) start1 = pk && (e == 2 || e == 3);
            else   start0 = pk && (e == 2 || e == 3);
            @(posedge clk); #1;
            if (e < n) begin
                chk("scan_sel",   s ? sel1 : sel0, 8'(e / per));
                chk("scan_busy",  s ? busy1 : busy0, 1);
                chk("scan_valid", s ? valid1 : valid0, 0);
            end else begin
                chk("end_valid",   s ? valid1 : valid0, 1);
                chk("end_word",    s ? word1 : word0, 8'(ew));
                chk("end_changed", s ? changed1 : changed0, 8'(ec));
                chk("end_busy",    s ? busy1 : busy0, 0);
                chk("end_sel",     s ? sel1 : sel0, 0);
            end
        end
        @(posedge clk); #1;
        chk("post_valid", s ? valid1 : valid0, 0);
        chk("post_busy",  s ? busy1 : busy0, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0101, 1'b0, 4'b0101, 1'b1};
        vecs[1] = '{1'b1, 4'b0101, 1'b1, 4'b0101, 1'b0};
        vecs[2] = '{1'b1, 4'b1111, 1'b0, 4'b1111, 1'b1};
        vecs[3] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1};
        vecs[4] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1};
        vecs[5] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1};
        vecs[6] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0};
        vecs[7] = '{1'b0, 4'b0111, 1'b0, 4'b0111, 1'b1};

        rst_n = 1'b0;
        start1 = 1'b0; start0 = 1'b0; cont1 = 1'b0; cont0 = 1'b0;
        mi1 = 4'b0000; mi0 = 4'b0000;
        #23;
        chk_zero(1'b1, "rst1");
        chk_zero(1'b0, "rst0");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy1", busy1, 0);
        chk("idle_valid1", valid1, 0);

        for (int i = 0; i < 8; i++)
            run_scan(vecs[i].s, vecs[i].iv, vecs[i].poke, vecs[i].ew, vecs[i].ec);

        // Continuous: previous word is 0001; mux flips to 1010 before channel 3 sample
        @(negedge clk);
        mi1 = 4'b0101; cont1 = 1'b1; start1 = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            if (e > 0) begin
                @(negedge clk);
                start1 = 1'b0;
                if (e == 7)  mi1 = 4'b1010;
                if (e == 19) cont1 = 1'b0;
            end
            @(posedge clk); #1;
            chk("cont_valid", valid1, (e == 8 || e == 16 || e == 24) ? 1 : 0);
            chk("cont_busy",  busy1, (e < 24) ? 1 : 0);
            chk("cont_sel",   sel1, (e < 24) ? 8'((e % 8) / 2) : 0);
            if (e == 8) begin
                chk("cont_w1", word1, 8'b1101);
                chk("cont_c1", changed1, 1);
            end
            if (e == 16) begin
                chk("cont_w2", word1, 8'b1010);
                chk("cont_c2", changed1, 1);
            end
            if (e == 24) begin
                chk("cont_w3", word1, 8'b1010);
                chk("cont_c3", changed1, 0);
            end
        end

        // Reset mid-scan at edge 5 while sel=2
        @(negedge clk);
        mi1 = 4'b0110; start1 = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk); start1 = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("pre_rst_sel", sel1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(1'b1, "mid_rst1");
        chk_zero(1'b0, "mid_rst0");
        @(negedge clk); rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            chk("hold_valid", valid1, 0);
            chk("hold_word",  word1, 0);
            chk("hold_busy",  busy1, 0);
        end
        run_scan(1'b1, 4'b0110, 1'b0, 4'b0110, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 4-to-1 gate-level multiplexer (`mux_4x1`). It drives the mux select lines through channels 0..3, waits a programmable settle time on each channel, and samples the mux output `Y`. It then assembles the four samples into a parallel word, publishes it with a one-cycle valid strobe and flags whether it differs from the previous word. It supports single-shot and continuous scanning.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles the select is held before sampling. Legal range 0..15; counter width is 4 bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  begin a scan; sampled only in IDLE.
- `cont`  input  1  continuous mode; sampled at the final sample edge of each scan.
- `mux_y`  input  1  mux output `Y`.
- `sel`  output  2  mux select `S`; registered.
- `word`  output  4  last completed scan; bit c = sample of channel c.
- `valid`  output  1  one-cycle strobe: `word` just updated.
- `changed`  output  1  qualified by `valid`: new `word` differs from the previous `word`.
- `busy`  output  1  high while in SCAN.

## Operation
- Registers: `state` (IDLE/SCAN), `ch` (2b), `cnt` (4b), `shadow` (3b, channels 0..2), `word`, `valid`, `changed`.
- Reset values: `state`=IDLE, `sel`=0, `ch`=0, `cnt`=0, `shadow`=0, `word`=0, `valid`=0, `changed`=0, `busy`=0.
- IDLE: `sel`=0, `valid` and `changed` return to 0 after their strobe cycle. On `start`=1 → SCAN, `ch`=0, `cnt`=0.
- SCAN, each edge:
  - If `cnt`<`SETTLE`: `cnt`++.
  - Otherwise, on the sample edge: capture `mux_y` for channel `ch`, set `cnt`=0, and set `ch`=`ch`+1.
- `sel` always equals `ch`. It changes on the same edge the previous channel is sampled, so every sample sees `sel` stable for `SETTLE`+1 cycles.
- Final sample edge (`ch`=3):
  - `word` <= {`mux_y`, `shadow[2:0]`}.
  - `valid` <= 1.
  - `changed` <= (new word != old `word`).
  - If `cont`=1: stay in SCAN with `ch`=0 and `cnt`=0. Otherwise go to IDLE.
- `ch` wraps 3→0 only at the final sample edge. `cnt` never exceeds `SETTLE`.
- `start` while `busy` is ignored, with no restart or queueing.
- `start`=1 held continuously in IDLE starts a new scan on the next edge after return to IDLE.
- Deasserting `cont` mid-scan lets the current scan finish, then the block goes to IDLE. Asserting `cont` mid single-shot makes the scan continuous if `cont` is high at the final edge.
- The first scan after reset compares against `word`=0.
- Reset mid-scan clears everything immediately (asynchronous). No `valid` is issued for the partial scan.

## Timing
- Let edge k be the edge where `start` is seen in IDLE. `busy`=1 and `sel`=0 from edge k.
- Channel c is sampled at edge k+(c+1)(`SETTLE`+1).
- `word`/`valid`/`changed` update at edge k+4(`SETTLE`+1); `valid` is high for exactly one cycle.
- Single-shot: `busy` falls at that same edge.
- Continuous: scans are back-to-back, one word every 4(`SETTLE`+1) cycles, with no idle gap and `busy` held high.
- Sampling assumes the mux is purely combinational; `mux_y` must settle within `SETTLE`+1 cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-activity → all outputs 0 immediately; hold 0 until the first `start` after release.
- Single scan, `SETTLE`=1, mux with I=4'b0101, `start` pulse at edge 0 → `sel` = 0,0,1,1,2,2,3,3 over edges 0..7; at edge 8 `word`=0101, `valid`=1 for one cycle, `changed`=1, `busy`=0.
- Repeat the identical scan → `word`=0101, `valid`=1, `changed`=0; `start` pulses during the scan are ignored (scan length stays 8 cycles).
- Continuous, `SETTLE`=1, `cont`=1, I changed to 1010 during the first scan's channel-3 window → words at edges 8 and 16; the second word is 1010 with `changed`=1. Drop `cont` at edge 18 → final word at edge 24, then IDLE.
- `SETTLE`=0, I=4'b1000 → `sel` 0,1,2,3 on consecutive cycles; `word`=1000 and `valid` at edge 4.
- Reset pulse at edge 5 of a `SETTLE`=1 scan (`sel`=2) → no `valid`, `word`=0. A new `start` then produces a correct full scan.
